cpu_mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the risc_cpu instruction-fetch (IF) unit and its load/store (LS) unit.
- Grants one access at a time using round-robin on conflict.
- Sequences the fixed memory latency with an FSM and routes each read response, or write acknowledge, back to the requester that issued it.
- Sits between the CPU core and the unified program/data memory.

---
 rtl/cpu_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_arbiter
// Purpose  : Round-robin arbiter sharing one fixed-latency synchronous memory
//            between the CPU instruction-fetch and load/store units.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] C_CNT_INIT = 4'(MEM_LAT - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_owner_ls, w_owner_ls_nxt;
    logic       r_last_ls, w_last_ls_nxt;
    logic       r_ls_is_write, w_ls_is_write_nxt;
    logic       w_win_ls;

    // On conflict the unit that did not win last time gets the memory
    assign w_win_ls = (if_req & ls_req) ? ~r_last_ls : ls_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_owner_ls    <= 1'b0;
            r_last_ls     <= 1'b1;
            r_ls_is_write <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_owner_ls    <= w_owner_ls_nxt;
            r_last_ls     <= w_last_ls_nxt;
            r_ls_is_write <= w_ls_is_write_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_owner_ls_nxt    = r_owner_ls;
        w_last_ls_nxt     = r_last_ls;
        w_ls_is_write_nxt = r_ls_is_write;
        if_gnt            = 1'b0;
        ls_gnt            = 1'b0;
        if_rvalid         = 1'b0;
        ls_rvalid         = 1'b0;
        if_rdata          = '0;
        ls_rdata          = '0;
        mem_en            = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        busy              = 1'b0;

        // Reset masks every output, even when the state register still holds RESP
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (if_req | ls_req) begin
                        mem_en            = 1'b1;
                        if_gnt            = ~w_win_ls;
                        ls_gnt            = w_win_ls;
                        mem_addr          = w_win_ls ? ls_addr : if_addr;
                        mem_we            = w_win_ls & ls_we;
                        mem_wdata         = (w_win_ls & ls_we) ? ls_wdata : '0;
                        w_owner_ls_nxt    = w_win_ls;
                        w_last_ls_nxt     = w_win_ls;
                        w_ls_is_write_nxt = w_win_ls & ls_we;
                        if (MEM_LAT == 1) begin
                            w_state_nxt = S_RESP;
                        end else begin
                            w_cnt_nxt   = C_CNT_INIT;
                            w_state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    busy      = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = S_RESP;
                    end
                end
                S_RESP: begin
                    busy        = 1'b1;
                    w_state_nxt = S_IDLE;
                    if (r_owner_ls) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = r_ls_is_write ? '0 : mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_arbiter
// Purpose  : Self-checking bench for cpu_mem_arbiter against a cycle-count
//            reference model of the arbitration and latency rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

    logic        reset1, if_req1;
    logic [31:0] if_addr1, mem_rdata1;
    logic        if_gnt1, if_rvalid1, ls_gnt1, ls_rvalid1, mem_en1, mem_we1, busy1;
    logic [31:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset1),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0),
        .ls_gnt(ls_gnt1), .ls_rvalid(ls_rvalid1), .ls_rdata(ls_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: one outstanding access described by its issue cycle
    bit m_active, m_owner_ls, m_wr, m_last_ls;
    int m_issue;

    // Snapshot of the outputs seen in the most recent step
    logic        o_ifg, o_lsg, o_ifv, o_lsv, o_en, o_we, o_busy;
    logic [31:0] o_ifd, o_lsd, o_wd;
    int          gnt_cyc[$];
    bit          gnt_ls[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Inputs are already driven; check this cycle at the falling edge, then advance
    task automatic step();
        logic        e_ifg, e_lsg, e_ifv, e_lsv, e_en, e_we, e_busy;
        logic [31:0] e_ifd, e_lsd, e_addr, e_wd;
        bit          win_ls;
        @(negedge clk);
        {e_ifg, e_lsg, e_ifv, e_lsv, e_en, e_we, e_busy} = '0;
        e_ifd = '0; e_lsd = '0; e_addr = '0; e_wd = '0;
        if (reset) begin
            m_active  = 1'b0;
            m_last_ls = 1'b1;
        end else begin
            e_busy = m_active && (cyc > m_issue) && (cyc <= m_issue + LAT);
            if (m_active && cyc == m_issue + LAT) begin
                if (m_owner_ls) begin
                    e_lsv = 1'b1;
                    e_lsd = m_wr ? 32'h0 : mem_rdata;
                end else begin
                    e_ifv = 1'b1;
                    e_ifd = mem_rdata;
                end
            end
            if ((!m_active || cyc > m_issue + LAT) && (if_req || ls_req)) begin
                win_ls = (if_req && ls_req) ? !m_last_ls : ls_req;
                e_en   = 1'b1;
                e_ifg  = !win_ls;
                e_lsg  = win_ls;
                e_addr = win_ls ? ls_addr : if_addr;
                e_we   = win_ls && ls_we;
                e_wd   = (win_ls && ls_we) ? ls_wdata : 32'h0;
                m_active = 1'b1; m_issue = cyc; m_owner_ls = win_ls;
                m_wr = win_ls && ls_we; m_last_ls = win_ls;
            end
        end
        chk("if_gnt", 32'(if_gnt), 32'(e_ifg));
        chk("ls_gnt", 32'(ls_gnt), 32'(e_lsg));
        chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
        chk("ls_rvalid", 32'(ls_rvalid), 32'(e_lsv));
        chk("if_rdata", if_rdata, e_ifd);
        chk("ls_rdata", ls_rdata, e_lsd);
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("busy", 32'(busy), 32'(e_busy));
        o_ifg = if_gnt; o_lsg = ls_gnt; o_ifv = if_rvalid; o_lsv = ls_rvalid;
        o_en = mem_en; o_we = mem_we; o_busy = busy;
        o_ifd = if_rdata; o_lsd = ls_rdata; o_wd = mem_wdata;
        if (if_gnt || ls_gnt) begin
            gnt_cyc.push_back(cyc);
            gnt_ls.push_back(ls_gnt);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        reset = 1'b1; if_req = 1'b1; if_addr = 32'h10;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
        reset1 = 1'b1; if_req1 = 1'b0; if_addr1 = '0; mem_rdata1 = '0;
        @(posedge clk); #1;

        // Reset dominates a pending request
        step();
        step();
        chk("reset_if_gnt", 32'(o_ifg), 32'h0);
        chk("reset_busy", 32'(o_busy), 32'h0);

        // First cycle out of reset: IF read at 0x10
        reset = 1'b0;
        step();
        chk("first_if_gnt", 32'(o_ifg), 32'h1);
        if_req = 1'b0;
        step();
        chk("if_read_busy", 32'(o_busy), 32'h1);
        mem_rdata = 32'hDEADBEEF;
        step();
        chk("if_read_rvalid", 32'(o_ifv), 32'h1);
        chk("if_read_rdata", o_ifd, 32'hDEADBEEF);
        chk("if_read_ls_quiet", 32'(o_lsv), 32'h0);

        // LS write gets a zero-data acknowledge
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h1234;
        step();
        chk("ls_wr_mem_we", 32'(o_we), 32'h1);
        chk("ls_wr_wdata", o_wd, 32'h1234);
        ls_req = 1'b0;
        step();
        mem_rdata = 32'hCAFEF00D;
        step();
        chk("ls_wr_ack", 32'(o_lsv), 32'h1);
        chk("ls_wr_rdata", o_lsd, 32'h0);

        // Continuous conflict: IF, LS, IF, LS spaced LAT+1 apart
        gnt_cyc.delete(); gnt_ls.delete();
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
        t0 = cyc;
        for (int i = 0; i < 12; i++) begin
            mem_rdata = $urandom;
            step();
        end
        chk("rr_count", 32'(gnt_cyc.size()), 32'd4);
        for (int i = 0; i < 4 && i < gnt_cyc.size(); i++) begin
            chk("rr_cycle", 32'(gnt_cyc[i] - t0), 32'(i * 3));
            chk("rr_unit", 32'(gnt_ls[i]), 32'(i % 2));
        end
        if_req = 1'b0; ls_req = 1'b0;
        step();

        // Reset in the middle of an LS read
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80;
        step();
        chk("abort_gnt", 32'(o_lsg), 32'h1);
        ls_req = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("abort_no_rvalid", 32'(o_lsv), 32'h0);
        chk("abort_idle", 32'(o_busy), 32'h0);

        // Randomised traffic with occasional resets and dropped requests
        for (int i = 0; i < 400; i++) begin
            mem_rdata = $urandom;
            reset = ($urandom_range(0, 99) < 2);
            if (o_ifg || !if_req) begin
                if_req = $urandom_range(0, 1);
                if_addr = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                if_req = 1'b0;
            end
            if (o_lsg || !ls_req) begin
                ls_req = $urandom_range(0, 1);
                ls_we = $urandom_range(0, 1);
                ls_addr = $urandom;
                ls_wdata = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                ls_req = 1'b0;
            end
            step();
        end
        reset = 1'b0; if_req = 1'b0; ls_req = 1'b0;

        // Single-cycle latency build: IF grants every other cycle
        reset1 = 1'b0; if_req1 = 1'b1; if_addr1 = 32'h20;
        for (int k = 0; k < 10; k++) begin
            mem_rdata1 = $urandom;
            @(negedge clk);
            chk("lat1_gnt", 32'(if_gnt1), 32'(k % 2 == 0));
            chk("lat1_rvalid", 32'(if_rvalid1), 32'(k % 2 == 1));
            chk("lat1_rdata", if_rdata1, (k % 2 == 1) ? mem_rdata1 : 32'h0);
            chk("lat1_busy", 32'(busy1), 32'(k % 2 == 1));
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
